// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline constants: hazard FSM state encodings, register-zero index
// and the packed stage-control bundle used by the hazard unit.
package mips32_pkg;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMdBusy  = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  localparam logic [4:0] RegZero = 5'd0;

  // Wide enough for the largest legal MD_CYCLES-1 (62).
  localparam int unsigned MdCntW = 6;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic idExWrite;
    logic exMemWrite;
    logic memWbWrite;
    logic ifIdFlush;
    logic idExFlush;
  } hazCtrlT;

  localparam hazCtrlT CtrlRun    = 7'b11111_00;
  localparam hazCtrlT CtrlStall  = 7'b00111_01;
  localparam hazCtrlT CtrlFlush  = 7'b11111_11;
  localparam hazCtrlT CtrlFreeze = 7'b00000_00;

  // True when an ID source operand depends on a non-zero EX destination.
  function automatic logic srcHit(input logic rdEn, input logic [4:0] src,
                                  input logic [4:0] dest);
    return rdEn && (src == dest) && (dest != RegZero);
  endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// Mult/div occupancy down-counter: load MD_CYCLES-1, decrement when enabled, flag zero.
module hazard_md_counter
  import mips32_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic decEn,
  output logic isZero
);

  localparam logic [MdCntW-1:0] LoadVal = MdCntW'(MD_CYCLES - 1);

  logic [MdCntW-1:0] cntQ, cntD;

  always_comb begin
    cntD = cntQ;
    if (load) begin
      cntD = LoadVal;
    end else if (decEn && (cntQ != '0)) begin
      cntD = cntQ - MdCntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign isZero = (cntQ == '0);

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use stall, branch flush, memory-wait freeze and stall counting.
// Define HAZARD_MULDIV_EN to add the mult/div busy state, counter and mdBusy tracking.
module hazard_control
  import mips32_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rsId,
  input  logic [4:0]       rtId,
  input  logic             useRsId,
  input  logic             useRtId,
  input  logic [4:0]       destRegEx,
  input  logic             memReadEx,
  input  logic             branchTakenEx,
  input  logic             mdStartEx,
  input  logic             mdUseId,
  input  logic             memReady,
  input  logic             memReqMem,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             idExWrite,
  output logic             exMemWrite,
  output logic             memWbWrite,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  logic [1:0]       stateQ, stateD;
  logic [CNT_W-1:0] stallQ, stallD;
  logic             loadUse, freeze, mdHaz;
  hazCtrlT          ctrl;

  assign loadUse = memReadEx &&
                   (srcHit(useRsId, rsId, destRegEx) || srcHit(useRtId, rtId, destRegEx));

  // A pending MEM access freezes the cycle it is seen, not one cycle later.
  assign freeze = ((stateQ == StMemWait) || memReqMem) && !memReady;

`ifdef HAZARD_MULDIV_EN
  logic [1:0] retQ, retD;
  logic [1:0] effState;
  logic       mdLoad, mdDec, mdZero;

  // The release cycle of a memory wait behaves as the interrupted state.
  assign effState = (stateQ == StMemWait) ? retQ : stateQ;
  assign mdHaz    = (effState == StMdBusy) && mdUseId;
  assign mdLoad   = !freeze && (effState == StRun) && mdStartEx;
  assign mdDec    = !freeze && (effState == StMdBusy);
  assign mdBusy   = !reset && (effState == StMdBusy);

  hazard_md_counter #(
    .MD_CYCLES(MD_CYCLES)
  ) uMdCounter (
    .clock (clock),
    .reset (reset),
    .load  (mdLoad),
    .decEn (mdDec),
    .isZero(mdZero)
  );

  always_comb begin
    stateD = effState;
    retD   = retQ;
    if (freeze) begin
      stateD = StMemWait;
      retD   = effState;
    end else if (mdLoad) begin
      stateD = StMdBusy;
    end else if ((effState == StMdBusy) && mdZero) begin
      stateD = StRun;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retQ <= StRun;
    end else begin
      retQ <= retD;
    end
  end
`else
  logic unusedMd;
  assign unusedMd = ^{mdStartEx, mdUseId, (MD_CYCLES != 0), StMdBusy};
  assign mdHaz    = 1'b0;
  assign mdBusy   = 1'b0;

  always_comb begin
    stateD = freeze ? StMemWait : StRun;
  end
`endif

  always_comb begin
    ctrl = CtrlRun;
    if (reset) begin
      ctrl = CtrlRun;
    end else if (freeze) begin
      ctrl = CtrlFreeze;
    end else if (branchTakenEx) begin
      ctrl = CtrlFlush;
    end else if (loadUse || mdHaz) begin
      ctrl = CtrlStall;
    end
  end

  always_comb begin
    stallD = stallQ;
    if (!ctrl.pcWrite && (stallQ != '1)) begin
      stallD = stallQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= StRun;
      stallQ <= '0;
    end else begin
      stateQ <= stateD;
      stallQ <= stallD;
    end
  end

  assign pcWrite    = ctrl.pcWrite;
  assign ifIdWrite  = ctrl.ifIdWrite;
  assign idExWrite  = ctrl.idExWrite;
  assign exMemWrite = ctrl.exMemWrite;
  assign memWbWrite = ctrl.memWbWrite;
  assign ifIdFlush  = ctrl.ifIdFlush;
  assign idExFlush  = ctrl.idExFlush;
  assign stallCount = stallQ;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus randomized traffic
// compared every cycle against a remaining-cycles / wait-flag reference model.
module tb_hazard_control;

  localparam int unsigned MdCycles = 4;
  localparam int unsigned CntW     = 8;
  localparam int          StallMax = 255;
`ifdef HAZARD_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  localparam logic [6:0] ExpRun    = 7'b11111_00;
  localparam logic [6:0] ExpStall  = 7'b00111_01;
  localparam logic [6:0] ExpFlush  = 7'b11111_11;
  localparam logic [6:0] ExpFreeze = 7'b00000_00;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] rsId, rtId, destRegEx;
  logic useRsId, useRtId, memReadEx, branchTakenEx, mdStartEx, mdUseId, memReady, memReqMem;
  logic pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush, mdBusy;
  logic [CntW-1:0] stallCount;

  int nAssert = 0;
  int nFail   = 0;

  hazard_control #(
    .MD_CYCLES(MdCycles),
    .CNT_W    (CntW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rsId         (rsId),
    .rtId         (rtId),
    .useRsId      (useRsId),
    .useRtId      (useRtId),
    .destRegEx    (destRegEx),
    .memReadEx    (memReadEx),
    .branchTakenEx(branchTakenEx),
    .mdStartEx    (mdStartEx),
    .mdUseId      (mdUseId),
    .memReady     (memReady),
    .memReqMem    (memReqMem),
    .pcWrite      (pcWrite),
    .ifIdWrite    (ifIdWrite),
    .idExWrite    (idExWrite),
    .exMemWrite   (exMemWrite),
    .memWbWrite   (memWbWrite),
    .ifIdFlush    (ifIdFlush),
    .idExFlush    (idExFlush),
    .mdBusy       (mdBusy),
    .stallCount   (stallCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrlVec();
    return {pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush};
  endfunction

  // Reference model: wait flag, mult/div cycles still to occupy, stall total.
  bit modelOn = 1'b0;
  bit mWait = 1'b0, nWait = 1'b0;
  int mMdLeft = 0, nMdLeft = 0;
  int mStalls = 0, nStalls = 0;
  bit frz, lu, mdStall;
  logic [6:0] eCtrl;
  bit eBusy;

  always @(negedge clock) begin
    if (modelOn) begin
      lu = memReadEx && (destRegEx != 5'd0) &&
           ((useRsId && (rsId == destRegEx)) || (useRtId && (rtId == destRegEx)));
      frz = (mWait || memReqMem) && !memReady;
      mdStall = (mMdLeft > 0) && mdUseId;
      if (reset) begin
        eCtrl = ExpRun;
        eBusy = 1'b0;
        nWait = 1'b0;
        nMdLeft = 0;
        nStalls = 0;
      end else begin
        if (frz) eCtrl = ExpFreeze;
        else if (branchTakenEx) eCtrl = ExpFlush;
        else if (lu || mdStall) eCtrl = ExpStall;
        else eCtrl = ExpRun;
        eBusy = (mMdLeft > 0);
        nStalls = (eCtrl[6] == 1'b0 && mStalls < StallMax) ? mStalls + 1 : mStalls;
        if (frz) begin
          nWait = 1'b1;
          nMdLeft = mMdLeft;
        end else begin
          nWait = 1'b0;
          if (mMdLeft > 0) nMdLeft = mMdLeft - 1;
          else if (MdEn && mdStartEx) nMdLeft = MdCycles;
          else nMdLeft = 0;
        end
      end
      check("model ctrl", 32'(ctrlVec()), 32'(eCtrl));
      check("model mdBusy", 32'(mdBusy), 32'(eBusy));
      check("model stallCount", 32'(stallCount), 32'(mStalls));
    end
  end

  always @(posedge clock) begin
    if (modelOn) begin
      mWait   <= nWait;
      mMdLeft <= nMdLeft;
      mStalls <= nStalls;
    end
  end

  task automatic idle();
    rsId = 5'd0; rtId = 5'd0; destRegEx = 5'd0;
    useRsId = 1'b0; useRtId = 1'b0; memReadEx = 1'b0; branchTakenEx = 1'b0;
    mdStartEx = 1'b0; mdUseId = 1'b0; memReady = 1'b1; memReqMem = 1'b0;
  endtask

  task automatic nextCyc();
    @(posedge clock);
    #1;
  endtask

  task automatic probe();
    @(negedge clock);
    #1;
  endtask

  task automatic loadUseInputs();
    memReadEx = 1'b1; destRegEx = 5'd5;
    rsId = 5'd5; useRsId = 1'b1; rtId = 5'd1; useRtId = 1'b1;
  endtask

  task automatic randomInputs(input int resetOdds);
    rsId = 5'($urandom_range(0, 3));
    rtId = 5'($urandom_range(0, 3));
    destRegEx = 5'($urandom_range(0, 3));
    useRsId = 1'($urandom_range(0, 1));
    useRtId = 1'($urandom_range(0, 1));
    memReadEx = ($urandom_range(0, 9) < 3);
    branchTakenEx = ($urandom_range(0, 9) == 0);
    mdStartEx = ($urandom_range(0, 19) == 0);
    mdUseId = ($urandom_range(0, 9) < 3);
    memReqMem = ($urandom_range(0, 9) < 3);
    memReady = ($urandom_range(0, 3) != 0);
    reset = (resetOdds > 0) && ($urandom_range(1, resetOdds) == 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;
    nextCyc();
    modelOn = 1'b1;
    probe();
    check("reset ctrl", 32'(ctrlVec()), 32'(ExpRun));
    check("reset stallCount", 32'(stallCount), 32'd0);
    check("reset mdBusy", 32'(mdBusy), 32'd0);

    // Load-use: lw $5 in EX, add $6,$5,$1 in ID.
    nextCyc(); reset = 1'b0; loadUseInputs();
    probe();
    check("load-use ctrl", 32'(ctrlVec()), 32'(ExpStall));
    nextCyc(); idle();
    probe();
    check("load-use stallCount", 32'(stallCount), 32'd1);
    check("after load-use ctrl", 32'(ctrlVec()), 32'(ExpRun));

    // Load to $0 read as rs=0 never stalls.
    nextCyc(); memReadEx = 1'b1; destRegEx = 5'd0; rsId = 5'd0; useRsId = 1'b1;
    rtId = 5'd0; useRtId = 1'b1;
    probe();
    check("reg0 no stall", 32'(ctrlVec()), 32'(ExpRun));

    // Taken branch overrides load-use.
    nextCyc(); idle(); loadUseInputs(); branchTakenEx = 1'b1;
    probe();
    check("branch over load-use", 32'(ctrlVec()), 32'(ExpFlush));
    nextCyc(); idle();
    probe();
    check("branch no stall count", 32'(stallCount), 32'd1);

    // Memory wait of three cycles.
    nextCyc(); reset = 1'b1;
    nextCyc(); reset = 1'b0; memReqMem = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe();
      check($sformatf("mem freeze %0d", i), 32'(ctrlVec()), 32'(ExpFreeze));
      nextCyc();
    end
    memReady = 1'b1;
    probe();
    check("mem release ctrl", 32'(ctrlVec()), 32'(ExpRun));
    check("mem release stallCount", 32'(stallCount), 32'd3);

`ifdef HAZARD_MULDIV_EN
    // Mult/div occupies four cycles; dependent ID instruction waits throughout.
    nextCyc(); idle(); reset = 1'b1;
    nextCyc(); reset = 1'b0; mdStartEx = 1'b1;
    probe();
    check("md start busy", 32'(mdBusy), 32'd0);
    nextCyc(); mdStartEx = 1'b0; mdUseId = 1'b1;
    for (int i = 0; i < 4; i++) begin
      probe();
      check($sformatf("md busy %0d", i), 32'(mdBusy), 32'd1);
      check($sformatf("md stall %0d", i), 32'(ctrlVec()), 32'(ExpStall));
      nextCyc();
    end
    probe();
    check("md done busy", 32'(mdBusy), 32'd0);
    check("md done ctrl", 32'(ctrlVec()), 32'(ExpRun));
    check("md stallCount", 32'(stallCount), 32'd4);
`else
    // Mult/div inputs have no effect in this build.
    nextCyc(); idle(); mdStartEx = 1'b1;
    nextCyc(); mdStartEx = 1'b0; mdUseId = 1'b1;
    probe();
    check("md ignored busy", 32'(mdBusy), 32'd0);
    check("md ignored ctrl", 32'(ctrlVec()), 32'(ExpRun));
`endif

    // Reset mid memory wait leaves no residual freeze.
    nextCyc(); idle(); reset = 1'b1;
    nextCyc(); reset = 1'b0; memReqMem = 1'b1; memReady = 1'b0;
    nextCyc();
    probe();
    check("wait before reset", 32'(ctrlVec()), 32'(ExpFreeze));
    nextCyc(); reset = 1'b1; memReqMem = 1'b0;
    probe();
    check("reset in wait ctrl", 32'(ctrlVec()), 32'(ExpRun));
    nextCyc(); reset = 1'b0;
    probe();
    check("post reset ctrl", 32'(ctrlVec()), 32'(ExpRun));
    check("post reset stallCount", 32'(stallCount), 32'd0);

    // Random traffic with occasional resets, then a long run to reach saturation.
    for (int i = 0; i < 1500; i++) begin
      nextCyc(); randomInputs(50);
    end
    nextCyc(); idle(); reset = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      nextCyc(); randomInputs(0);
    end
    nextCyc(); idle(); reset = 1'b0;
    probe();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32: EX-stage cycles one mult/div occupies (legal 2..63).
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 SHALL have one clock and a synchronous active-high reset:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-004 SHALL have these pipeline-status inputs:
- rsId, rtId  in  5 each  ID-stage source registers.
- useRsId, useRtId  in  1 each  ID instruction reads rs/rt.
- destRegEx  in  5  EX-stage destination register.
- memReadEx  in  1  EX instruction is a load.
- branchTakenEx  in  1  branch/jump resolved taken in EX.
- mdStartEx  in  1  mult/div entering EX this cycle.
- mdUseId  in  1  ID instruction is mfhi/mflo/mult/div.
- memReady  in  1  data memory completes the MEM access.
- memReqMem  in  1  MEM stage holds a load/store.
REQ-005 SHALL have these control/status outputs:
- pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite  out  1 each  stage register enables.
- ifIdFlush, idExFlush  out  1 each  insert bubble.
- mdBusy  out  1  mult/div unit occupied.
- stallCount  out  CNT_W  cycles with pcWrite=0.

Function
REQ-006 SHALL hold FSM states RUN, MD_BUSY and MEM_WAIT in a registered state; outputs SHALL be combinational from state and current inputs.
REQ-007 SHALL detect load-use: memReadEx=1, destRegEx!=0, and (useRsId && rsId==destRegEx, or useRtId && rtId==destRegEx).
REQ-008 Load-use SHALL hold pcWrite=0, ifIdWrite=0 and idExFlush=1 for exactly one cycle, with all other enables 1.
REQ-009 branchTakenEx SHALL assert ifIdFlush=1 and idExFlush=1, keep pcWrite=1, and override a simultaneous load-use.
REQ-010 In RUN, memReqMem=1 with memReady=0 SHALL enter MEM_WAIT in the same cycle.
REQ-011 While memReady=0 in MEM_WAIT, all five enables SHALL be 0 and both flushes 0 (full freeze).
REQ-012 MEM_WAIT SHALL return to RUN in the cycle memReady=1, with enables 1 in that cycle.
REQ-013 Freeze SHALL take priority over branch flush and load-use; frozen inputs re-present the event after release.
REQ-014 mdStartEx in RUN SHALL load a down-counter with MD_CYCLES-1, set mdBusy=1 and enter MD_BUSY.
REQ-015 In MD_BUSY the counter SHALL decrement each non-frozen cycle; at 0 the FSM SHALL return to RUN and clear mdBusy.
REQ-016 In MD_BUSY with mdUseId=1, the ID instruction SHALL stall as in REQ-008; independent instructions SHALL proceed.
REQ-017 MEM_WAIT during MD_BUSY SHALL pause the mult/div counter; the return state SHALL be saved and restored.
REQ-018 stallCount SHALL increment in every cycle with pcWrite=0 and saturate at all-ones.
REQ-019 rsId/rtId equal to 0 SHALL never cause a stall.

Reset
REQ-020 Reset SHALL set state=RUN, counter=0, stallCount=0 and mdBusy=0, with all enables 1 and flushes 0 from the first cycle it is sampled.
REQ-021 Reset asserted mid-MEM_WAIT or mid-MD_BUSY SHALL abandon the operation with no residual stall.

Configuration
REQ-022 Macro HAZARD_MULDIV_EN defined SHALL compile in MD_BUSY, the mult/div counter and mdBusy tracking.
REQ-023 Without HAZARD_MULDIV_EN, mdBusy SHALL be tied 0 and mdStartEx/mdUseId ignored; the FSM has only RUN and MEM_WAIT.

Structure
REQ-024 FSM state encodings and the register-zero constant SHALL live in shared package mips32_pkg.
REQ-025 Sub-module hazard_md_counter SHALL implement the mult/div down-counter (load, decrement enable, zero flag).

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Load-use: lw $5 in EX, add $6,$5,$1 in ID -> one cycle pcWrite=0, idExFlush=1, stallCount=1.
- Load to $0 with rsId=0 -> no stall.
- branchTakenEx=1 together with load-use -> ifIdFlush=idExFlush=1, pcWrite=1.
- memReqMem=1, memReady low for 3 cycles -> all enables 0 for 3 cycles, stallCount=3, RUN on the 4th cycle.
- HAZARD_MULDIV_EN, MD_CYCLES=4, mdStartEx then mdUseId=1 -> mdBusy high 4 cycles, ID stalled until cleared.
- Reset during MEM_WAIT -> next cycle all enables 1, stallCount=0, state RUN.
